rom_read_arbiter: RTL and testbench

//  Shares the single read port of the 1 KB sky130 ROM between two requesters (req0, req1).

---
 rtl/rom_read_arbiter_if.sv | 36 +++
 rtl/rom_read_arbiter.sv | 119 +++++++++++
 tb/tb_rom_read_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rom_read_arbiter_if.sv
// Bundles both requester handshakes and the ROM read port of rom_read_arbiter.
// master = requesters plus ROM macro side; slave = the arbiter itself.
interface rom_read_arbiter_if #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 8
);
   logic                  req0_valid;
   logic [ADDR_WIDTH-1:0] req0_addr;
   logic                  req0_ready;
   logic                  rsp0_valid;
   logic [DATA_WIDTH-1:0] rsp0_data;

   logic                  req1_valid;
   logic [ADDR_WIDTH-1:0] req1_addr;
   logic                  req1_ready;
   logic                  rsp1_valid;
   logic [DATA_WIDTH-1:0] rsp1_data;

   logic                  rom_cs;
   logic [ADDR_WIDTH-1:0] rom_addr;
   logic [DATA_WIDTH-1:0] rom_dout;

   modport master (
      output req0_valid, req0_addr, req1_valid, req1_addr, rom_dout,
      input  req0_ready, rsp0_valid, rsp0_data,
      input  req1_ready, rsp1_valid, rsp1_data,
      input  rom_cs, rom_addr
   );

   modport slave (
      input  req0_valid, req0_addr, req1_valid, req1_addr, rom_dout,
      output req0_ready, rsp0_valid, rsp0_data,
      output req1_ready, rsp1_valid, rsp1_data,
      output rom_cs, rom_addr
   );
endinterface

// File: rtl/rom_read_arbiter.sv
// Round-robin arbiter sharing the single sky130 ROM read port between two requesters.
// The ROM samples cs/addr on negedge, so dout is captured on the posedge after the last held negedge.
module rom_read_arbiter #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 8,
   parameter int RD_WAIT    = 0
) (
   input  logic              clk,
   input  logic              resetn,
   rom_read_arbiter_if.slave bus
);
   typedef enum logic {IDLE, READ} state_t;

   localparam logic [2:0] WAIT_INIT = 3'(RD_WAIT);

   state_t                state_reg, state_next;
   logic [2:0]            cnt_reg;
   logic                  owner_reg;
   logic                  last_reg;
   logic                  rom_cs_reg;
   logic [ADDR_WIDTH-1:0] rom_addr_reg;

   logic                  grant_valid;
   logic                  grant;
   logic                  capture;
   logic [1:0]            req_valid;

   assign req_valid = {bus.req1_valid, bus.req0_valid};
   assign capture   = (state_reg == READ) && (cnt_reg == 3'd0);

   always_comb begin
      state_next  = state_reg;
      grant_valid = 1'b0;
      grant       = 1'b0;
      case (state_reg)
         IDLE: begin
            // On a tie, the requester not served last time wins.
            if (req_valid == 2'b11) begin
               grant_valid = 1'b1;
               grant       = ~last_reg;
            end else if (req_valid[0]) begin
               grant_valid = 1'b1;
               grant       = 1'b0;
            end else if (req_valid[1]) begin
               grant_valid = 1'b1;
               grant       = 1'b1;
            end
            if (grant_valid) begin
               state_next = READ;
            end
         end
         READ: begin
            if (cnt_reg == 3'd0) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_reg    <= IDLE;
         cnt_reg      <= 3'd0;
         owner_reg    <= 1'b0;
         last_reg     <= 1'b1;
         rom_cs_reg   <= 1'b0;
         rom_addr_reg <= '0;
      end else begin
         state_reg <= state_next;
         case (state_reg)
            IDLE: begin
               if (grant_valid) begin
                  rom_cs_reg   <= 1'b1;
                  rom_addr_reg <= grant ? bus.req1_addr : bus.req0_addr;
                  owner_reg    <= grant;
                  last_reg     <= grant;
                  cnt_reg      <= WAIT_INIT;
               end
            end
            READ: begin
               // cs stays high through the wait cycles so every negedge re-reads the address.
               if (cnt_reg != 3'd0) begin
                  cnt_reg <= cnt_reg - 3'd1;
               end else begin
                  rom_cs_reg <= 1'b0;
               end
            end
            default: rom_cs_reg <= 1'b0;
         endcase
      end
   end

   for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
      logic                  rsp_valid_reg;
      logic [DATA_WIDTH-1:0] rsp_data_reg;

      always_ff @(posedge clk or negedge resetn) begin
         if (!resetn) begin
            rsp_valid_reg <= 1'b0;
            rsp_data_reg  <= '0;
         end else begin
            rsp_valid_reg <= capture && (owner_reg == 1'(gi));
            if (capture && (owner_reg == 1'(gi))) begin
               rsp_data_reg <= bus.rom_dout;
            end
         end
      end
   end

   assign bus.req0_ready = grant_valid && !grant;
   assign bus.req1_ready = grant_valid && grant;
   assign bus.rsp0_valid = g_rsp[0].rsp_valid_reg;
   assign bus.rsp0_data  = g_rsp[0].rsp_data_reg;
   assign bus.rsp1_valid = g_rsp[1].rsp_valid_reg;
   assign bus.rsp1_data  = g_rsp[1].rsp_data_reg;
   assign bus.rom_cs     = rom_cs_reg;
   assign bus.rom_addr   = rom_addr_reg;
endmodule

// File: tb/tb_rom_read_arbiter.sv
// Bench for rom_read_arbiter: three instances (RD_WAIT 0, 3, 2) against a negedge ROM model
// and a transaction-level reference model of grants, cs windows and responses.
module tb_rom_read_arbiter;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [7:0] mem [1024];

   // Bench-side views of each instance, index [instance][requester].
   logic       rstn [3];
   logic       v    [3][2];
   logic [9:0] a    [3][2];
   logic       rdy  [3][2];
   logic       rspv [3][2];
   logic [7:0] rspd [3][2];
   logic       cs   [3];
   logic [9:0] ra   [3];

   for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      rom_read_arbiter_if #(.ADDR_WIDTH(10), .DATA_WIDTH(8)) bus ();
      logic [7:0] dout_g;

      assign bus.req0_valid = v[gi][0];
      assign bus.req0_addr  = a[gi][0];
      assign bus.req1_valid = v[gi][1];
      assign bus.req1_addr  = a[gi][1];
      assign bus.rom_dout   = dout_g;
      assign rdy[gi][0]     = bus.req0_ready;
      assign rdy[gi][1]     = bus.req1_ready;
      assign rspv[gi][0]    = bus.rsp0_valid;
      assign rspv[gi][1]    = bus.rsp1_valid;
      assign rspd[gi][0]    = bus.rsp0_data;
      assign rspd[gi][1]    = bus.rsp1_data;
      assign cs[gi]         = bus.rom_cs;
      assign ra[gi]         = bus.rom_addr;

      rom_read_arbiter #(
         .ADDR_WIDTH(10),
         .DATA_WIDTH(8),
         .RD_WAIT   ((gi == 0) ? 0 : (gi == 1) ? 3 : 2)
      ) u_dut (
         .clk   (clk),
         .resetn(rstn[gi]),
         .bus   (bus.slave)
      );

      // ROM: samples cs/addr at negedge, garbage shortly after, valid word later if selected.
      always @(negedge clk) begin : rom
         logic       sel;
         logic [9:0] ad;
         sel = bus.rom_cs;
         ad  = bus.rom_addr;
         #1 dout_g = 8'($urandom);
         if (sel) begin
            #2 dout_g = mem[ad];
         end
      end
   end

   int n_assert = 0;
   int n_fail   = 0;
   int c        = 0;

   // Reference model state.
   int         free_at [3];
   int         last    [3];
   int         due     [3][2];
   logic [7:0] dq      [3][2];
   logic [7:0] xd      [3][2];
   logic [9:0] cur_addr[3];
   bit         gnt     [3][2];

   // Snapshots of DUT outputs taken at the sample point of the last cycle.
   logic       s_rdy  [3][2];
   logic       s_rspv [3][2];
   logic [7:0] s_rspd [3][2];
   logic       s_cs   [3];

   task automatic check(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s inst%0d cycle %0d: observed %0h expected %0h", tag, k, c, obs, exp);
      end
   endtask

   function automatic int wait_of(input int k);
      return (k == 0) ? 0 : (k == 1) ? 3 : 2;
   endfunction

   // One clock: sample and compare at negedge+1, then return at posedge+1 for the next drive.
   task automatic cycle();
      int   g;
      int   w;
      logic ev;
      logic cs_exp;
      @(negedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         w = wait_of(k);
         if (!rstn[k]) begin
            free_at[k] = c;
            last[k]    = 1;
            for (int r = 0; r < 2; r++) begin
               due[k][r] = -1;
               xd[k][r]  = 8'h00;
            end
         end
         for (int r = 0; r < 2; r++) begin
            s_rdy[k][r]  = rdy[k][r];
            s_rspv[k][r] = rspv[k][r];
            s_rspd[k][r] = rspd[k][r];
            gnt[k][r]    = 1'b0;
            ev = (due[k][r] == c);
            if (ev) xd[k][r] = dq[k][r];
            check($sformatf("rsp%0d_valid", r), k, 32'(rspv[k][r]), 32'(ev));
            check($sformatf("rsp%0d_data", r), k, 32'(rspd[k][r]), 32'(xd[k][r]));
         end
         s_cs[k] = cs[k];
         cs_exp  = rstn[k] && (c < free_at[k]);
         check("rom_cs", k, 32'(cs[k]), 32'(cs_exp));
         if (cs_exp) check("rom_addr", k, 32'(ra[k]), 32'(cur_addr[k]));
         g = -1;
         if (rstn[k] && c >= free_at[k]) begin
            if (v[k][0] && v[k][1]) g = 1 - last[k];
            else if (v[k][0])       g = 0;
            else if (v[k][1])       g = 1;
         end
         check("req0_ready", k, 32'(rdy[k][0]), 32'(g == 0));
         check("req1_ready", k, 32'(rdy[k][1]), 32'(g == 1));
         if (g >= 0) begin
            last[k]     = g;
            free_at[k]  = c + 2 + w;
            due[k][g]   = c + 2 + w;
            dq[k][g]    = mem[a[k][g]];
            cur_addr[k] = a[k][g];
            gnt[k][g]   = 1'b1;
         end
      end
      @(posedge clk);
      #1;
      c++;
   endtask

   initial begin
      int ncs;
      int nrsp;
      int rsp_at;
      int prev_g;
      int prev_c;
      int ngr;
      int skip [3][2];

      for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
      for (int k = 0; k < 3; k++) begin
         rstn[k]     = 1'b0;
         free_at[k]  = 0;
         last[k]     = 1;
         cur_addr[k] = '0;
         for (int r = 0; r < 2; r++) begin
            v[k][r]    = 1'b0;
            a[k][r]    = '0;
            due[k][r]  = -1;
            dq[k][r]   = '0;
            xd[k][r]   = '0;
            skip[k][r] = 0;
         end
      end

      // Reset state.
      repeat (3) cycle();
      for (int k = 0; k < 3; k++) check("reset rom_addr", k, 32'(ra[k]), 32'h0);
      for (int k = 0; k < 3; k++) rstn[k] = 1'b1;
      cycle();

      // Single read, RD_WAIT=0, req0 at 0x005.
      v[0][0] = 1'b1; a[0][0] = 10'h005;
      cycle();
      check("t1 grant", 0, 32'(s_rdy[0][0]), 32'd1);
      v[0][0] = 1'b0;
      ncs = 0; nrsp = 0;
      for (int i = 0; i < 3; i++) begin
         cycle();
         if (s_cs[0]) ncs++;
         if (s_rspv[0][1]) nrsp++;
         if (s_rspv[0][0]) check("t1 rsp0_data", 0, 32'(s_rspd[0][0]), 32'(mem[10'h005]));
      end
      check("t1 cs cycles", 0, 32'(ncs), 32'd1);
      check("t1 rsp1 pulses", 0, 32'(nrsp), 32'd0);

      // RD_WAIT=3, req1 at 0x3FF.
      v[1][1] = 1'b1; a[1][1] = 10'h3FF;
      cycle();
      v[1][1] = 1'b0;
      ncs = 0; rsp_at = -1;
      for (int i = 1; i <= 6; i++) begin
         cycle();
         if (s_cs[1]) ncs++;
         if (s_rspv[1][1]) begin
            rsp_at = i;
            check("t3 rsp1_data", 1, 32'(s_rspd[1][1]), 32'(mem[10'h3FF]));
         end
      end
      check("t3 cs cycles", 1, 32'(ncs), 32'd4);
      check("t3 rsp cycle", 1, 32'(rsp_at), 32'd5);

      // req1 waits while req0's read is in flight.
      v[0][0] = 1'b1; a[0][0] = 10'h111;
      cycle();
      v[0][0] = 1'b0; v[0][1] = 1'b1; a[0][1] = 10'h222;
      cycle();
      check("t4 ready1 busy", 0, 32'(s_rdy[0][1]), 32'd0);
      cycle();
      check("t4 ready1 idle", 0, 32'(s_rdy[0][1]), 32'd1);
      v[0][1] = 1'b0;
      cycle();
      cycle();
      check("t4 rsp1_valid", 0, 32'(s_rspv[0][1]), 32'd1);
      check("t4 rsp1_data", 0, 32'(s_rspd[0][1]), 32'(mem[10'h222]));

      // Both valid continuously: alternating grants every 2 cycles.
      v[0][0] = 1'b1; a[0][0] = 10'h010;
      v[0][1] = 1'b1; a[0][1] = 10'h020;
      prev_g = -1; prev_c = -1; ngr = 0;
      for (int i = 0; i < 12; i++) begin
         cycle();
         for (int r = 0; r < 2; r++) begin
            if (gnt[0][r]) begin
               if (prev_g >= 0) begin
                  check("t2 alternate", 0, 32'(r), 32'(1 - prev_g));
                  check("t2 spacing", 0, 32'(c - 1 - prev_c), 32'd2);
               end
               prev_g = r; prev_c = c - 1; ngr++;
            end
         end
      end
      check("t2 grant count", 0, 32'(ngr), 32'd6);
      v[0][0] = 1'b0; v[0][1] = 1'b0;
      repeat (3) cycle();

      // Reset during READ with RD_WAIT=2.
      v[2][1] = 1'b1; a[2][1] = 10'h077;
      cycle();
      v[2][1] = 1'b0;
      repeat (5) cycle();
      v[2][0] = 1'b1; a[2][0] = 10'h0AB;
      cycle();
      v[2][0] = 1'b0;
      cycle();
      rstn[2] = 1'b0;
      #1;
      check("t5 cs async", 2, 32'(cs[2]), 32'd0);
      check("t5 addr async", 2, 32'(ra[2]), 32'd0);
      check("t5 rsp1_data async", 2, 32'(rspd[2][1]), 32'd0);
      check("t5 rsp0_valid async", 2, 32'(rspv[2][0]), 32'd0);
      check("t5 ready async", 2, 32'({rdy[2][1], rdy[2][0]}), 32'd0);
      cycle();
      cycle();
      rstn[2] = 1'b1;
      nrsp = 0;
      for (int i = 0; i < 5; i++) begin
         cycle();
         if (s_rspv[2][0] || s_rspv[2][1]) nrsp++;
      end
      check("t5 no rsp after reset", 2, 32'(nrsp), 32'd0);
      v[2][0] = 1'b1; a[2][0] = 10'h0CD;
      v[2][1] = 1'b1; a[2][1] = 10'h0EF;
      cycle();
      check("t5 tie req0", 2, 32'({s_rdy[2][1], s_rdy[2][0]}), 32'b01);
      v[2][0] = 1'b0; v[2][1] = 1'b0;
      repeat (4) cycle();

      // Random traffic on all instances.
      for (int n = 0; n < 2000; n++) begin
         cycle();
         for (int k = 0; k < 3; k++) begin
            for (int r = 0; r < 2; r++) begin
               if (gnt[k][1 - r] && v[k][r]) begin
                  skip[k][r]++;
                  check("starvation", k, 32'(skip[k][r] <= 1), 32'd1);
               end
               if (gnt[k][r] || !v[k][r]) skip[k][r] = 0;
            end
            for (int r = 0; r < 2; r++) begin
               if (gnt[k][r] || !v[k][r]) begin
                  v[k][r] = ($urandom_range(0, 2) != 0);
                  a[k][r] = 10'($urandom);
               end else if ($urandom_range(0, 31) == 0) begin
                  v[k][r] = 1'b0;
               end
            end
         end
      end
      for (int k = 0; k < 3; k++) begin
         v[k][0] = 1'b0;
         v[k][1] = 1'b0;
      end
      repeat (8) cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
